chad_copctl: RTL and testbench

Coprocessor controller for the chad CPU. It decodes `copgo` and the select field, and runs iterative unsigned multiply and divide over `copa`/`copb`/`copc`. It stalls the core through `hold` until the result is valid, then presents it on `cop`. It sits beside the core and drives the core's `cop` input; its `hold` output is ORed with other wait sources at the top level.

---
 rtl/chad_cop_pkg.sv | 27 ++
 rtl/chad_copctl_if.sv | 33 +++
 rtl/chad_muldiv_step.sv | 51 +++++
 rtl/chad_copctl.sv | 156 +++++++++++++++
 tb/tb_chad_copctl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/chad_cop_pkg.sv
// chad_cop_pkg: shared definitions for the chad coprocessor controller.
// Holds the opcode values decoded from sel[2:0], the controller state
// encoding, the bit positions of the status word returned by RDST, and a
// helper that tells which opcodes run on the iterative datapath.
package chad_cop_pkg;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_RDHI = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_RDST = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Status word layout: {0..., dz, ovf}
  localparam int ST_OVF = 0;
  localparam int ST_DZ  = 1;

  // MUL and DIV take the multi-cycle path; every other opcode is single-cycle.
  function automatic logic is_multi(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/chad_copctl_if.sv
// chad_copctl_if: core <-> coprocessor bundle.
//   copgo  : coprocessor instruction present this cycle (core -> cop)
//   sel    : instruction select field insn[10:0]       (core -> cop)
//   stall  : other wait sources are holding the core    (core -> cop)
//   copa   : T, divisor / multiplicand                 (core -> cop)
//   copb   : N, multiplier / low dividend word         (core -> cop)
//   copc   : W, high dividend word                     (core -> cop)
//   cop    : result                                     (cop -> core)
//   hold   : coprocessor wait request                   (cop -> core)
//   busy   : controller not idle                        (cop -> core)
interface chad_copctl_if #(
  parameter int WIDTH = 18
);
  logic             copgo;
  logic [10:0]      sel;
  logic             stall;
  logic [WIDTH-1:0] copa;
  logic [WIDTH-1:0] copb;
  logic [WIDTH-1:0] copc;
  logic [WIDTH-1:0] cop;
  logic             hold;
  logic             busy;

  modport master (
    output copgo, sel, stall, copa, copb, copc,
    input  cop, hold, busy
  );

  modport slave (
    input  copgo, sel, stall, copa, copb, copc,
    output cop, hold, busy
  );
endinterface

// File: rtl/chad_muldiv_step.sv
// chad_muldiv_step: one combinational iteration of the unsigned multiplier
// or restoring divider.
//   mode_div : 0 = shift-add multiply step, 1 = shift-subtract divide step
//   acc_hi   : upper accumulator word (partial product high / remainder)
//   acc_lo   : lower accumulator word (multiplier bits / dividend bits, quotient)
//   opnd     : multiplicand or divisor
//   nxt_hi   : next upper accumulator word
//   nxt_lo   : next lower accumulator word
//   qbit     : quotient bit produced by a divide step (0 in multiply mode)
module chad_muldiv_step #(
  parameter int WIDTH = 18
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             qbit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    qbit   = 1'b0;
    sum    = '0;
    trial  = '0;
    diff   = '0;
    if (mode_div) begin
      // Shift the next dividend bit into the remainder; the trial value is
      // one bit wider so a remainder with its top bit set still compares right.
      trial  = {acc_hi, acc_lo[WIDTH-1]};
      qbit   = (trial >= {1'b0, opnd});
      // When the subtraction is taken the result always fits in WIDTH bits.
      diff   = trial[WIDTH-1:0] - opnd;
      nxt_hi = qbit ? diff : trial[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], qbit};
    end else begin
      // Add the multiplicand when the current multiplier LSB is set, then
      // shift {carry, hi, lo} right by one.
      sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/chad_copctl.sv
// chad_copctl: coprocessor controller for the chad CPU.
// Decodes copgo/sel[2:0], runs WIDTH-step unsigned multiply and restoring
// divide, stalls the core through hold until the result is ready, and
// returns results, the HI register and sticky status flags on cop.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : chad_copctl_if slave side (copgo, sel, stall, copa/b/c in;
//           cop, hold, busy out)
module chad_copctl
  import chad_cop_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic          clk,
  input  logic          reset,
  chad_copctl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;

  logic [2:0]         op;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               step_qbit;
  logic               unused_bits;

  assign op          = bus.sel[2:0];
  // Only sel[2:0] is decoded; quotient bits are already folded into step_lo.
  assign unused_bits = &{1'b0, bus.sel[10:3], step_qbit};

  chad_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (mode_q),
    .acc_hi   (acc_hi_q),
    .acc_lo   (acc_lo_q),
    .opnd     (opnd_q),
    .nxt_hi   (step_hi),
    .nxt_lo   (step_lo),
    .qbit     (step_qbit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    hi_d     = hi_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    bus.hold = 1'b0;
    bus.cop  = '0;
    bus.busy = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (bus.copgo) begin
          unique case (op)
            OP_RDHI: bus.cop = hi_q;
            OP_RDST: begin
              bus.cop         = '0;
              bus.cop[ST_OVF] = ovf_q;
              bus.cop[ST_DZ]  = dz_q;
              // A stalled RDST is re-presented next cycle, so only clear
              // once the core actually retires it.
              if (!bus.stall) begin
                ovf_d = 1'b0;
                dz_d  = 1'b0;
              end
            end
            default: bus.cop = '0;
          endcase

          if (is_multi(op)) begin
            bus.hold = 1'b1;
            mode_d   = (op == OP_DIV);
            acc_hi_d = (op == OP_DIV) ? bus.copc : '0;
            acc_lo_d = bus.copb;
            opnd_d   = bus.copa;
            cnt_d    = CNT_W'(WIDTH - 1);
            state_d  = BUSY;
            // Divide cases whose quotient cannot fit skip the iterations.
            if ((op == OP_DIV) && (bus.copa == '0)) begin
              state_d = DONE;
              res_d   = '1;
              hi_d    = bus.copb;
              dz_d    = 1'b1;
            end else if ((op == OP_DIV) && (bus.copc >= bus.copa)) begin
              state_d = DONE;
              res_d   = '1;
              hi_d    = '1;
              ovf_d   = 1'b1;
            end
          end
        end
      end

      BUSY: begin
        bus.hold = 1'b1;
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          res_d   = step_lo;
          hi_d    = step_hi;
        end
      end

      DONE: begin
        // copgo here is the same instruction still waiting to retire.
        bus.cop = res_q;
        if (!bus.stall) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  // Datapath registers carry no reset; they are reloaded on every issue and
  // cop is muxed to zero outside DONE.
  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    mode_q   <= mode_d;
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
    opnd_q   <= opnd_d;
    res_q    <= res_d;
  end

endmodule

// File: tb/tb_chad_copctl.sv
// tb_chad_copctl: directed plus randomized bench for chad_copctl, WIDTH = 18.
// Expected results come from a reference model using plain 64-bit arithmetic
// (product, quotient, remainder) and tracked HI/flag variables.
module tb_chad_copctl;
  import chad_cop_pkg::*;

  localparam int W = 18;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chad_copctl_if #(.WIDTH(W)) bus ();

  chad_copctl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_hi;
  logic         m_ovf;
  logic         m_dz;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for MUL/DIV: result word, cycles hold stays high, HI/flag update.
  task automatic model_multi(input logic [2:0] op, input logic [W-1:0] a, b, c,
                             output logic [W-1:0] res, output int cyc);
    longint unsigned p;
    longint unsigned dvd;
    cyc = W + 1;
    if (op == OP_MUL) begin
      p    = 64'(a) * 64'(b);
      res  = W'(p);
      m_hi = W'(p >> W);
    end else if (a == '0) begin
      res   = '1;
      m_hi  = b;
      m_dz  = 1'b1;
      cyc   = 1;
    end else if (c >= a) begin
      res   = '1;
      m_hi  = '1;
      m_ovf = 1'b1;
      cyc   = 1;
    end else begin
      dvd  = (64'(c) << W) | 64'(b);
      res  = W'(dvd / 64'(a));
      m_hi = W'(dvd % 64'(a));
    end
  endtask

  task automatic do_multi(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, b, c,
                          input int dstall, input bit istall);
    logic [W-1:0] exp;
    logic [7:0]   up;
    int           cyc;
    int           n;
    model_multi(op, a, b, c, exp, cyc);
    up        = 8'($urandom);
    bus.sel   = {up, op};
    bus.copa  = a;
    bus.copb  = b;
    bus.copc  = c;
    bus.copgo = 1'b1;
    bus.stall = istall;
    #1;
    n = 0;
    while (bus.hold === 1'b1 && n < 4 * W) begin
      n++;
      tick();
      bus.stall = 1'b0;
    end
    check({tag, "/hold_cycles"}, 64'(n), 64'(cyc));
    check({tag, "/busy_done"}, 64'(bus.busy), 64'd1);
    check({tag, "/cop"}, 64'(bus.cop), 64'(exp));
    for (int i = 0; i < dstall; i++) begin
      bus.stall = 1'b1;
      tick();
      check({tag, "/stall_busy"}, 64'(bus.busy), 64'd1);
      check({tag, "/stall_hold"}, 64'(bus.hold), 64'd0);
      check({tag, "/stall_cop"}, 64'(bus.cop), 64'(exp));
    end
    bus.stall = 1'b0;
    bus.copgo = 1'b0;
    tick();
    check({tag, "/back_idle"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic do_single(input string tag, input logic [2:0] op, input bit st);
    logic [W-1:0] exp;
    logic [7:0]   up;
    exp = '0;
    if (op == OP_RDHI) exp = m_hi;
    if (op == OP_RDST) begin
      exp[0] = m_ovf;
      exp[1] = m_dz;
      if (!st) begin
        m_ovf = 1'b0;
        m_dz  = 1'b0;
      end
    end
    up        = 8'($urandom);
    bus.sel   = {up, op};
    bus.copa  = W'($urandom);
    bus.copb  = W'($urandom);
    bus.copc  = W'($urandom);
    bus.copgo = 1'b1;
    bus.stall = st;
    #1;
    check({tag, "/cop"}, 64'(bus.cop), 64'(exp));
    check({tag, "/hold"}, 64'(bus.hold), 64'd0);
    tick();
    bus.copgo = 1'b0;
    bus.stall = 1'b0;
    check({tag, "/busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b, c;
    int           k;

    reset     = 1'b1;
    bus.copgo = 1'b0;
    bus.sel   = '0;
    bus.stall = 1'b0;
    bus.copa  = '0;
    bus.copb  = '0;
    bus.copc  = '0;
    m_hi      = '0;
    m_ovf     = 1'b0;
    m_dz      = 1'b0;
    tick();
    tick();
    check("rst/hold", 64'(bus.hold), 64'd0);
    check("rst/busy", 64'(bus.busy), 64'd0);
    check("rst/cop", 64'(bus.cop), 64'd0);
    reset = 1'b0;
    tick();
    do_single("rst_rdhi", OP_RDHI, 1'b0);
    do_single("rst_rdst", OP_RDST, 1'b0);

    do_multi("mul_max", OP_MUL, 18'h3FFFF, 18'h3FFFF, 18'h0, 0, 1'b0);
    do_single("mul_max_rdhi", OP_RDHI, 1'b0);

    do_multi("div_basic", OP_DIV, 18'h00002, 18'h00000, 18'h00001, 0, 1'b0);
    do_single("div_basic_rdhi", OP_RDHI, 1'b0);
    do_single("div_basic_rdst", OP_RDST, 1'b0);

    do_multi("div_ovf", OP_DIV, 18'h00005, 18'h00000, 18'h00005, 0, 1'b0);
    do_single("ovf_rdst_stalled", OP_RDST, 1'b1);
    do_single("ovf_rdst1", OP_RDST, 1'b0);
    do_single("ovf_rdst2", OP_RDST, 1'b0);

    do_multi("div_zero", OP_DIV, 18'h00000, 18'h12345, 18'h00007, 0, 1'b0);
    do_single("dz_rdhi", OP_RDHI, 1'b0);
    do_single("dz_rdst", OP_RDST, 1'b0);

    for (int i = 4; i < 8; i++) do_single("op_unused", 3'(i), 1'b0);

    do_multi("mul_stall_done", OP_MUL, 18'h2ABCD, 18'h1F00F, 18'h0, 3, 1'b1);
    do_single("mul_stall_rdhi", OP_RDHI, 1'b0);

    // Leave a sticky flag set, then reset in the 5th BUSY cycle of a MUL.
    do_multi("pre_reset_ovf", OP_DIV, 18'h00003, 18'h00001, 18'h3FFFF, 0, 1'b0);
    bus.sel   = {8'h0, OP_MUL};
    bus.copa  = 18'h12345;
    bus.copb  = 18'h23456;
    bus.copgo = 1'b1;
    tick();
    bus.copgo = 1'b0;
    repeat (4) tick();
    check("mid/busy", 64'(bus.busy), 64'd1);
    check("mid/hold", 64'(bus.hold), 64'd1);
    reset = 1'b1;
    tick();
    check("mid_rst/hold", 64'(bus.hold), 64'd0);
    check("mid_rst/busy", 64'(bus.busy), 64'd0);
    check("mid_rst/cop", 64'(bus.cop), 64'd0);
    reset = 1'b0;
    m_hi  = '0;
    m_ovf = 1'b0;
    m_dz  = 1'b0;
    do_single("mid_rst_rdhi", OP_RDHI, 1'b0);
    do_single("mid_rst_rdst", OP_RDST, 1'b0);

    for (int it = 0; it < 40; it++) begin
      k = int'($urandom_range(0, 3));
      if (k == 0) op = OP_MUL;
      else if (k == 1) op = OP_DIV;
      else op = 3'($urandom_range(0, 7));
      a = W'($urandom);
      b = W'($urandom);
      c = W'($urandom);
      if (op == OP_DIV) begin
        k = int'($urandom_range(0, 9));
        if (k == 0) a = '0;
        else if (k > 2) begin
          if (a == '0) a = 18'd1;
          c = W'($urandom_range(0, int'(a) - 1));
        end
      end
      if (op == OP_MUL || op == OP_DIV)
        do_multi("rand_multi", op, a, b, c, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else
        do_single("rand_single", op, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
